// File: rtl/box_filter_pkg.sv
// box_filter_pkg: shared widths, sample type and sum-width helper for the box filter
// No ports; imported by box_filter_window and box_filter_core.
package box_filter_pkg;
   localparam int DATA_W = 32;
   typedef logic [DATA_W-1:0] sample_t;
   // Running sum must hold n full-scale samples without wrapping.
   function automatic int sum_width(input int n);
      return DATA_W + $clog2(n + 1);
   endfunction
endpackage

// File: rtl/box_filter_window.sv
// box_filter_window: DEPTH-entry sample shift register with newest/oldest taps
// Ports: clk, rst (sync active-high), i_sample (captured every edge),
//        o_newest (w[0]), o_oldest (w[DEPTH-1]).
module box_filter_window
   import box_filter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  sample_t i_sample,
   output sample_t o_newest,
   output sample_t o_oldest
);
   sample_t r_w [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_w[k] <= '0;
      end else begin
         r_w[0] <= i_sample;
         for (int k = 1; k < DEPTH; k++) r_w[k] <= r_w[k-1];
      end
   end
   assign o_newest = r_w[0];
   assign o_oldest = r_w[DEPTH-1];
endmodule

// File: rtl/box_filter_core.sv
// box_filter_core: streaming moving-average over the last FILTER_SIZE samples
// Ports: clk, rst (sync active-high), in (sample, captured every edge),
//        out (truncated window average, registered-only path).
module box_filter_core
   import box_filter_pkg::*;
#(
   parameter int FILTER_SIZE = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  sample_t in,
   output sample_t out
);
   localparam int SW = sum_width(FILTER_SIZE);
   sample_t       w_newest;
   sample_t       w_oldest;
   logic [SW-1:0] r_sum;
   logic [SW-1:0] w_avg;
   box_filter_window #(.DEPTH(FILTER_SIZE)) u_window (
      .clk      (clk),
      .rst      (rst),
      .i_sample (in),
      .o_newest (w_newest),
      .o_oldest (w_oldest)
   );
   // Oldest tap is read before the shift, so it is exactly the sample leaving the window.
   always_ff @(posedge clk) begin
      if (rst) r_sum <= '0;
      else     r_sum <= r_sum + SW'(in) - SW'(w_oldest);
   end
   // Constant divisor: a shift for powers of two, constant division otherwise.
   assign w_avg = r_sum / SW'(FILTER_SIZE);
   // A one-sample window is just the newest tap; no divider needed.
   assign out = (FILTER_SIZE == 1) ? w_newest : DATA_W'(w_avg);
endmodule

// File: tb/tb_box_filter_core.sv
// tb_box_filter_core: directed + model-checked bench for window sizes 4, 3 and 1
module tb_box_filter_core;
   logic        clk = 0;
   logic        rst = 0;
   logic [31:0] in_s = 0;
   logic [31:0] out4, out3, out1;
   int          checks = 0;
   int          errors = 0;
   bit          armed = 0;
   logic [31:0] q4[$], q3[$], q1[$];

   always #5 clk = ~clk;

   box_filter_core #(.FILTER_SIZE(4)) dut4 (.clk(clk), .rst(rst), .in(in_s), .out(out4));
   box_filter_core #(.FILTER_SIZE(3)) dut3 (.clk(clk), .rst(rst), .in(in_s), .out(out3));
   box_filter_core #(.FILTER_SIZE(1)) dut1 (.clk(clk), .rst(rst), .in(in_s), .out(out1));

   function automatic logic [31:0] avg(input logic [31:0] q[$], input int n);
      longint s = 0;
      foreach (q[i]) s += longint'(q[i]);
      return 32'(s / n);
   endfunction

   task automatic win_update(inout logic [31:0] q[$], input int n);
      if (rst) begin
         q = {};
         repeat (n) q.push_front(32'd0);
      end else begin
         q.push_front(in_s);
         void'(q.pop_back());
      end
   endtask

   always @(posedge clk) begin
      win_update(q4, 4);
      win_update(q3, 3);
      win_update(q1, 1);
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp("model4", out4, avg(q4, 4));
         cmp("model3", out3, avg(q3, 3));
         cmp("model1", out1, avg(q1, 1));
      end
   end

   task automatic step(input logic [31:0] v, input logic r);
      @(negedge clk);
      in_s = v;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      step(32'd0, 1'b1);
      armed = 1;
      cmp("reset4", out4, 32'd0);
      cmp("reset3", out3, 32'd0);
      cmp("reset1", out1, 32'd0);
      step(32'd10, 0); cmp("ramp1", out4, 32'd2);
      step(32'd10, 0); cmp("ramp2", out4, 32'd5);
      step(32'd10, 0); cmp("ramp3", out4, 32'd7);
      step(32'd10, 0); cmp("ramp4", out4, 32'd10);
      step(32'd10, 0); cmp("ramp5", out4, 32'd10);
      step(32'd10, 0); cmp("ramp6", out4, 32'd10);
      cmp("ramp_n1", out1, 32'd10);
      step(32'd0, 1);  cmp("midrst", out4, 32'd0);
      step(32'd20, 0); cmp("restart", out4, 32'd5);
      step(32'd0, 1);
      step(32'd4, 0);  cmp("slide1", out4, 32'd1);
      step(32'd8, 0);  cmp("slide2", out4, 32'd3);
      step(32'd12, 0); cmp("slide3", out4, 32'd6);
      step(32'd16, 0); cmp("slide4", out4, 32'd10);
      step(32'd0, 0);  cmp("slide5", out4, 32'd9);
      step(32'd0, 0);  cmp("slide6", out4, 32'd7);
      step(32'd0, 1);
      step(32'hFFFF_FFFF, 0); cmp("max1", out4, 32'h3FFF_FFFF);
      step(32'hFFFF_FFFF, 0); cmp("max2", out4, 32'h7FFF_FFFF);
      step(32'hFFFF_FFFF, 0); cmp("max3", out4, 32'hBFFF_FFFF);
      cmp("max3_n3", out3, 32'hFFFF_FFFF);
      step(32'hFFFF_FFFF, 0); cmp("max4", out4, 32'hFFFF_FFFF);
      cmp("max_n1", out1, 32'hFFFF_FFFF);
      step(32'd0, 1);
      step(32'd7, 0); cmp("n3_1", out3, 32'd2);
      step(32'd7, 0); cmp("n3_2", out3, 32'd4);
      step(32'd7, 0); cmp("n3_3", out3, 32'd7);
      for (int i = 0; i < 40; i++) step($urandom, (i == 20));
      @(negedge clk);
      armed = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/box_filter_core.md
Name: box_filter_core

Overview:
- Streaming moving-average (box) filter over the most recent FILTER_SIZE 32-bit unsigned input samples.
- Captures one sample per clock and presents the truncated average of the window.
- Sits in the datapath as a simple smoothing stage.
- Matches the behavioural BoxFilter model: push one sample per cycle, read back the average.

Parameters:
- FILTER_SIZE, 4, window length in samples; integer >= 1. Powers of two are preferred (divide becomes a shift); other values must still work via constant division.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in  input  32  unsigned sample, captured every rising edge.
- out  output  32  unsigned truncated average of the current window.

Behaviour:
- State:
  - Window shift register: FILTER_SIZE x 32-bit entries, w[0] newest, w[FILTER_SIZE-1] oldest.
  - Running sum register, width 32+$clog2(FILTER_SIZE+1), so it never overflows.
- Reset: on a rising edge with rst=1, all window entries clear to 0 and the sum clears to 0. out is therefore 0 the cycle after reset. rst has priority over sample capture.
- Normal operation, each rising edge with rst=0:
  - Shift the window: w[0] <= in, w[k] <= w[k-1].
  - Update the sum: sum <= sum + in - w[FILTER_SIZE-1], using the pre-shift oldest entry.
- Output:
  - out = sum / FILTER_SIZE, unsigned, truncating toward zero, zero-extended or truncated to 32 bits (always fits).
  - Combinational from registers only; no path from in to out.
  - Latency: a sample captured at edge k first affects out right after edge k.
- Start-up: the window is pre-filled with zeros. Until FILTER_SIZE samples have arrived, the divisor is still FILTER_SIZE, not the sample count.
- FILTER_SIZE=1: out equals the last captured sample.
- Max values: FILTER_SIZE samples of 0xFFFFFFFF give out=0xFFFFFFFF. The sum width guarantees no wrap.
- Reset mid-stream: the whole history is discarded and out returns to 0 on the next edge. Subsequent averaging restarts from a zero-filled window.
- No handshake: every edge consumes a sample.
- X on in is not filtered; the bench drives in from the first post-reset edge.

Decomposition:
- Shared package box_filter_pkg:
  - DATA_W=32.
  - sample_t (logic [DATA_W-1:0]).
  - Function sum_width(n) returning DATA_W+$clog2(n+1).
- One sub-module is natural: box_filter_window, the parameterised shift register exposing newest and oldest taps. The top holds the running sum and the divider.

Test Plan:
- Reset then idle: assert rst for one edge -> out=0; window entries and sum all 0.
- Constant ramp-up, FILTER_SIZE=4, in=10 from the first edge after reset -> out after edges 1..6 = 2, 5, 7, 10, 10, 10.
- Sliding window, FILTER_SIZE=4, inputs 4, 8, 12, 16, 0, 0 -> out = 1, 3, 6, 10, 9, 7.
- Overflow guard, FILTER_SIZE=4, in=0xFFFFFFFF for 4 edges -> out = 0x3FFFFFFF, 0x7FFFFFFF, 0xBFFFFFFF, 0xFFFFFFFF; no wrap.
- Reset mid-stream: after out=10 steady, assert rst one edge -> out=0. Then in=20 -> out=5 on the next edge.
- Non-power-of-two FILTER_SIZE=3, inputs 7, 7, 7 -> out = 2, 4, 7 (truncation).
